// File: rtl/pa_hpcp_cnt_if.sv
// Event, CSR-write and counter-readback signals of one hardware performance counter.
// The master side (CSR/PMU logic) drives events and writes; the slave side is the counter.
interface pa_hpcp_cnt_if;
    logic [4:0]  event_sel;
    logic [31:0] hpcp_event_vld;
    logic        hpcp_cnt_inhibit;
    logic        hpcp_cnt_lo_wen;
    logic        hpcp_cnt_hi_wen;
    logic [31:0] hpcp_wdata;
    logic [31:0] cnt_lo_value;
    logic [31:0] cnt_hi_value;
    logic        cnt_ovf;

    modport master (
        output event_sel, hpcp_event_vld, hpcp_cnt_inhibit,
        output hpcp_cnt_lo_wen, hpcp_cnt_hi_wen, hpcp_wdata,
        input  cnt_lo_value, cnt_hi_value, cnt_ovf
    );

    modport slave (
        input  event_sel, hpcp_event_vld, hpcp_cnt_inhibit,
        input  hpcp_cnt_lo_wen, hpcp_cnt_hi_wen, hpcp_wdata,
        output cnt_lo_value, cnt_hi_value, cnt_ovf
    );
endinterface

// File: rtl/pa_hpcp_cnt.sv
// 64-bit event counter: selected event pulse is registered, then counted one cycle later.
// CSR writes to either half take priority over (and discard) the in-flight increment.
module pa_hpcp_cnt (
    input  logic           forever_cpuclk,
    input  logic           cpurst,
    pa_hpcp_cnt_if.slave   bus
);

    logic        evt_hit_q, evt_hit_d;
    logic [63:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        evt_hit_d = (bus.event_sel != 5'd0) && bus.hpcp_event_vld[bus.event_sel]
                    && !bus.hpcp_cnt_inhibit;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (bus.hpcp_cnt_lo_wen || bus.hpcp_cnt_hi_wen) begin
            // Each strobe loads its own half; the pending hit is dropped, not carried.
            if (bus.hpcp_cnt_lo_wen) cnt_d[31:0]  = bus.hpcp_wdata;
            if (bus.hpcp_cnt_hi_wen) cnt_d[63:32] = bus.hpcp_wdata;
        end else if (evt_hit_q) begin
            cnt_d = cnt_q + 64'd1;
            ovf_d = &cnt_q;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            evt_hit_q <= 1'b0;
            cnt_q     <= 64'd0;
            ovf_q     <= 1'b0;
        end else begin
            evt_hit_q <= evt_hit_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.cnt_lo_value = cnt_q[31:0];
    assign bus.cnt_hi_value = cnt_q[63:32];
    assign bus.cnt_ovf      = ovf_q;

endmodule

// File: tb/tb_pa_hpcp_cnt.sv
// Self-checking bench for pa_hpcp_cnt: directed scenarios plus a randomized run,
// all compared against a cycle-level reference model of the counter rules.
module tb_pa_hpcp_cnt;

    logic clk;
    logic rst;
    pa_hpcp_cnt_if bus ();

    pa_hpcp_cnt dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 64-bit count, overflow flag, and a one-deep queue of pending hits.
    logic [63:0] m_cnt;
    logic        m_ovf;
    bit          hit_pipe[$];

    task automatic idle_inputs();
        bus.event_sel        = 5'd0;
        bus.hpcp_event_vld   = 32'd0;
        bus.hpcp_cnt_inhibit = 1'b0;
        bus.hpcp_cnt_lo_wen  = 1'b0;
        bus.hpcp_cnt_hi_wen  = 1'b0;
        bus.hpcp_wdata       = 32'd0;
    endtask

    // Advance one clock with the currently driven inputs and update the model.
    task automatic step();
        bit old_hit, new_hit;
        old_hit = hit_pipe.pop_front();
        new_hit = (bus.event_sel != 0) && bus.hpcp_event_vld[bus.event_sel] && !bus.hpcp_cnt_inhibit;
        if (rst) begin
            m_cnt   = 64'd0;
            m_ovf   = 1'b0;
            new_hit = 1'b0;
        end else if (bus.hpcp_cnt_lo_wen || bus.hpcp_cnt_hi_wen) begin
            if (bus.hpcp_cnt_lo_wen) m_cnt[31:0]  = bus.hpcp_wdata;
            if (bus.hpcp_cnt_hi_wen) m_cnt[63:32] = bus.hpcp_wdata;
            m_ovf = 1'b0;
        end else if (old_hit) begin
            m_ovf = (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
            m_cnt = m_cnt + 64'd1;
        end else begin
            m_ovf = 1'b0;
        end
        hit_pipe.push_back(new_hit);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        n_tests++;
        if (bus.cnt_lo_value !== 32'd0) begin
            n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.cnt_lo_value, 32'd0);
        end
        n_tests++;
        if (bus.cnt_hi_value !== 32'd0) begin
            n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.cnt_hi_value, 32'd0);
        end
        n_tests++;
        if (bus.cnt_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.cnt_ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_count();
        bit ovf_seen;
        ovf_seen = 1'b0;
        bus.event_sel = 5'd5;
        for (int i = 0; i < 10; i++) begin
            bus.hpcp_event_vld = $urandom() | 32'h20;
            step();
            ovf_seen |= bus.cnt_ovf;
        end
        bus.hpcp_event_vld = 32'd0;
        step();
        ovf_seen |= bus.cnt_ovf;
        step();
        ovf_seen |= bus.cnt_ovf;
        n_tests++;
        if (bus.cnt_lo_value !== 32'd10 || bus.cnt_hi_value !== 32'd0) begin
            n_fail++; $display("FAIL count_ten: got %h_%h expected 0_a", bus.cnt_hi_value, bus.cnt_lo_value);
        end
        n_tests++;
        if (ovf_seen !== 1'b0) begin
            n_fail++; $display("FAIL count_no_ovf: got ovf %b expected 0", ovf_seen);
        end
    endtask

    task automatic test_filter();
        logic [31:0] lo0;
        lo0 = bus.cnt_lo_value;
        bus.event_sel = 5'd3;
        for (int i = 0; i < 6; i++) begin
            bus.hpcp_event_vld = (i % 2) ? 32'h4 : 32'h10;
            step();
        end
        bus.event_sel = 5'd0;
        for (int i = 0; i < 4; i++) begin
            bus.hpcp_event_vld = 32'h1;
            step();
        end
        bus.hpcp_event_vld = 32'd0;
        step();
        n_tests++;
        if (bus.cnt_lo_value !== lo0) begin
            n_fail++; $display("FAIL filter_hold: got %h expected %h", bus.cnt_lo_value, lo0);
        end
        bus.event_sel = 5'd3;
        bus.hpcp_event_vld = 32'h8;
        step();
        bus.hpcp_event_vld = 32'd0;
        step();
        n_tests++;
        if (bus.cnt_lo_value !== lo0 + 32'd1 || bus.cnt_lo_value !== m_cnt[31:0]) begin
            n_fail++; $display("FAIL filter_hit: got %h expected %h", bus.cnt_lo_value, lo0 + 32'd1);
        end
    endtask

    task automatic test_carry_wrap();
        bit ovf_seen;
        bus.event_sel = 5'd9;
        bus.hpcp_event_vld = 32'd0;
        bus.hpcp_cnt_lo_wen = 1'b1; bus.hpcp_wdata = 32'hFFFF_FFFF; step();
        bus.hpcp_cnt_lo_wen = 1'b0; bus.hpcp_cnt_hi_wen = 1'b1; bus.hpcp_wdata = 32'd0; step();
        bus.hpcp_cnt_hi_wen = 1'b0;
        bus.hpcp_event_vld = 32'h200; step();
        bus.hpcp_event_vld = 32'd0; step();
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf} !== {32'd1, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL carry: got %h_%h ovf %b expected 1_0 ovf 0",
                               bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf);
        end
        bus.hpcp_cnt_lo_wen = 1'b1; bus.hpcp_cnt_hi_wen = 1'b1; bus.hpcp_wdata = 32'hFFFF_FFFF; step();
        bus.hpcp_cnt_lo_wen = 1'b0; bus.hpcp_cnt_hi_wen = 1'b0;
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL dual_write: got %h_%h expected ffffffff_ffffffff",
                               bus.cnt_hi_value, bus.cnt_lo_value);
        end
        bus.hpcp_event_vld = 32'h200; step();
        bus.hpcp_event_vld = 32'd0; step();
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf} !== {64'd0, 1'b1}) begin
            n_fail++; $display("FAIL wrap: got %h_%h ovf %b expected 0_0 ovf 1",
                               bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf);
        end
        ovf_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            ovf_seen |= bus.cnt_ovf;
        end
        n_tests++;
        if (ovf_seen !== 1'b0) begin
            n_fail++; $display("FAIL ovf_one_cycle: got extra ovf %b expected 0", ovf_seen);
        end
    endtask

    task automatic test_collision();
        logic [31:0] hi0;
        bus.event_sel = 5'd7;
        bus.hpcp_event_vld = 32'h80;
        step(); step(); step();
        hi0 = bus.cnt_hi_value;
        bus.hpcp_cnt_lo_wen = 1'b1; bus.hpcp_wdata = 32'h100; step();
        bus.hpcp_cnt_lo_wen = 1'b0;
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value} !== {hi0, 32'h100}) begin
            n_fail++; $display("FAIL collide_write: got %h_%h expected %h_00000100",
                               bus.cnt_hi_value, bus.cnt_lo_value, hi0);
        end
        step();
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value} !== {hi0, 32'h101}) begin
            n_fail++; $display("FAIL collide_next: got %h_%h expected %h_00000101",
                               bus.cnt_hi_value, bus.cnt_lo_value, hi0);
        end
    endtask

    task automatic test_inhibit();
        logic [31:0] b;
        bus.event_sel = 5'd7;
        bus.hpcp_event_vld = 32'h80;
        step(); step();
        b = bus.cnt_lo_value;
        bus.hpcp_cnt_inhibit = 1'b1;
        step();
        n_tests++;
        if (bus.cnt_lo_value !== b + 32'd1) begin
            n_fail++; $display("FAIL inhibit_last: got %h expected %h", bus.cnt_lo_value, b + 32'd1);
        end
        step(); step(); step();
        n_tests++;
        if (bus.cnt_lo_value !== b + 32'd1) begin
            n_fail++; $display("FAIL inhibit_hold: got %h expected %h", bus.cnt_lo_value, b + 32'd1);
        end
        bus.hpcp_cnt_inhibit = 1'b0;
        step();
        n_tests++;
        if (bus.cnt_lo_value !== b + 32'd1) begin
            n_fail++; $display("FAIL resume_delay: got %h expected %h", bus.cnt_lo_value, b + 32'd1);
        end
        step();
        n_tests++;
        if (bus.cnt_lo_value !== b + 32'd2) begin
            n_fail++; $display("FAIL resume: got %h expected %h", bus.cnt_lo_value, b + 32'd2);
        end
    endtask

    task automatic test_reset_mid();
        bus.event_sel = 5'd7;
        bus.hpcp_event_vld = 32'h80;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        n_tests++;
        if ({bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf} !== 65'd0) begin
            n_fail++; $display("FAIL mid_reset: got %h_%h ovf %b expected 0",
                               bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf);
        end
        step();
        n_tests++;
        if (bus.cnt_lo_value !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_drop: got %h expected 0", bus.cnt_lo_value);
        end
        step();
        n_tests++;
        if (bus.cnt_lo_value !== 32'd1) begin
            n_fail++; $display("FAIL mid_reset_first: got %h expected 1", bus.cnt_lo_value);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            bus.event_sel        = 5'($urandom_range(0, 31));
            bus.hpcp_event_vld   = $urandom();
            bus.hpcp_cnt_inhibit = ($urandom_range(0, 7) == 0);
            bus.hpcp_cnt_lo_wen  = ($urandom_range(0, 15) == 0);
            bus.hpcp_cnt_hi_wen  = ($urandom_range(0, 15) == 0);
            bus.hpcp_wdata       = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom();
            rst                  = ($urandom_range(0, 63) == 0);
            step();
            n_tests++;
            if ({bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf} !== {m_cnt, m_ovf}) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got %h_%h ovf %b expected %h ovf %b", i,
                             bus.cnt_hi_value, bus.cnt_lo_value, bus.cnt_ovf, m_cnt, m_ovf);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_cnt = 64'd0;
        m_ovf = 1'b0;
        hit_pipe.push_back(1'b0);
        test_reset();
        test_count();
        test_filter();
        test_carry_wrap();
        test_collision();
        test_inhibit();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_hpcp_cnt.md
# pa_hpcp_cnt

Event-driven 64-bit hardware performance counter (mhpmcounterN / mhpmcounterNh) in the PMU, directly downstream of the per-counter event-selector register. Each cycle it muxes one of 32 event pulses using the 5-bit event selector value, registers the hit, and increments a 64-bit count. The count is exposed as two 32-bit CSR halves with independent write ports, and a one-cycle overflow pulse is produced on wrap.

## Interface
Parameters: none. Width fixed at 64 bits; 32 event inputs.

Ports:
- forever_cpuclk  in  1  free-running core clock; all state on rising edge.
- cpurst  in  1  reset, synchronous, active-high.
- event_sel  in  5  event index from the event-selector register (its low 5 output bits). Value 0 means no event.
- hpcp_event_vld  in  32  one-bit-per-event pulse vector. Bit k high means event k occurred this cycle. Bit 0 is ignored.
- hpcp_cnt_inhibit  in  1  this counter's mcountinhibit bit; 1 blocks counting.
- hpcp_cnt_lo_wen  in  1  CSR write strobe for the low half.
- hpcp_cnt_hi_wen  in  1  CSR write strobe for the high half.
- hpcp_wdata  in  32  CSR write data.
- cnt_lo_value  out  32  counter bits [31:0].
- cnt_hi_value  out  32  counter bits [63:32].
- cnt_ovf  out  1  one-cycle pulse when the counter wraps.

## Operation
- Stage 1 (event capture), evaluated every cycle:
  - evt_hit_q <= (event_sel != 0) & hpcp_event_vld[event_sel] & ~hpcp_cnt_inhibit.
  - event_sel and inhibit act on the event sampled in the same cycle; there is no selector pipelining.
- Stage 2 (count), in priority order:
  1. cpurst: counter = 0, evt_hit_q = 0, cnt_ovf = 0.
  2. Any CSR write (lo_wen or hi_wen):
     - The written half takes hpcp_wdata; the other half holds its value.
     - The increment from evt_hit_q in this cycle is discarded.
     - No carry into the high half.
     - cnt_ovf = 0.
  3. lo_wen and hi_wen in the same cycle: both halves load hpcp_wdata (same data to both); still one cycle, no increment.
  4. Otherwise, if evt_hit_q: counter = counter + 1 (full 64-bit carry). If the old value was all-ones, the counter wraps to 0 and cnt_ovf = 1.
  5. Otherwise the counter holds and cnt_ovf = 0.
- Stage 1 capture continues during a CSR-write cycle. An event sampled in the write cycle counts on the following cycle, on top of the written value.
- At most one increment per cycle. Inhibit does not affect CSR writes.
- Reset values: cnt_lo_value = 0, cnt_hi_value = 0, cnt_ovf = 0.

## Timing
- Event pulse at cycle N appears in cnt_*_value at cycle N+2 (registered hit, then registered count).
- A CSR write in cycle N is visible at cycle N+1.
- cnt_ovf is registered: it is high in exactly the one cycle in which the outputs first show 0 after the wrap, and low otherwise.
- Inhibit asserted in cycle N:
  - blocks the event sampled at N;
  - an evt_hit_q already captured at N-1 still counts at N+1.
- Changing event_sel at cycle N: the new event is sampled at N; the old event's hit already in evt_hit_q still counts.
- Reset asserted mid-count: the in-flight evt_hit_q is dropped. The first count after release needs an event sampled on or after the first non-reset cycle.

## Test plan
- Reset then count: hold cpurst 2 cycles; event_sel=5; pulse bit 5 for 10 consecutive cycles → lo reaches 10 two cycles after the last pulse; hi=0; cnt_ovf never high.
- Select filtering: event_sel=3; pulse bits 2 and 4 only → no change. Set event_sel=0 and pulse bit 0 → no change. Pulse bit 3 once → lo +1.
- Carry and wrap:
  - Write lo=0xFFFFFFFF, hi=0; one hit → hi=1, lo=0, no ovf.
  - Write both halves to 0xFFFFFFFF; one hit → both halves 0 and cnt_ovf high for exactly one cycle.
- Write vs increment collision: continuous hits on event 7. Write lo=0x100 in cycle N → lo=0x100 at N+1, 0x101 at N+2. hi is unchanged across the write.
- Inhibit timing: continuous hits; raise hpcp_cnt_inhibit at cycle N → exactly one further increment (at N+1), then the counter holds. Drop inhibit → counting resumes two cycles later.
- Reset mid-operation: continuous hits; assert cpurst one cycle → outputs 0 the next cycle; first increment appears two cycles after reset release.
